mem_lat_line: RTL and testbench



---
 rtl/mem_lat_line.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mem_lat_line.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lat_line.sv
// mem_lat_line: dual-port (instruction/data) line-transfer memory.
// Each port runs its own request/ready handshake with its own fixed latency.
// Transfers always move one whole aligned line. Storage is shared by both ports.
// Storage is never cleared by reset.

// Per-port transaction controller.
// It accepts a request and counts the latency down. It then raises a
// completion strobe for exactly one clock edge, and the top level uses that
// edge to move a line into or out of storage.
module mem_lat_line_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int IDX_W      = 8,
  parameter int LINE_W     = 64,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 2,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LINE_W-1:0]     wdata,
  output logic                  busy,
  output logic                  ready,
  output logic                  done,
  output logic                  done_we,
  output logic [IDX_W-1:0]      done_base,
  output logic [LINE_W-1:0]     done_wdata
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  localparam logic [IDX_W-1:0] OFFSET_MASK = IDX_W'(LINE_WORDS - 1);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               busy_d;
  logic               ready_d;
  logic               capture;
  logic               we_q;
  logic [IDX_W-1:0]   base_q;
  logic [LINE_W-1:0]  wdata_q;
  logic [IDX_W-1:0]   req_base;

  // Upper address bits are dropped so that addresses wrap modulo DEPTH.
  // The word offset within the line is then cleared to give the line base.
  assign req_base = IDX_W'(addr) & ~OFFSET_MASK;

  // Next-state logic.
  // The counter holds the number of clock edges still to go before
  // completion. Completion therefore falls on the edge L-1 edges after
  // acceptance. A latency of 1 completes on the acceptance edge itself.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy;
    ready_d    = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    done_we    = we_q;
    done_base  = base_q;
    done_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            done       = 1'b1;
            done_we    = we;
            done_base  = req_base;
            done_wdata = wdata;
            ready_d    = 1'b1;
            busy_d     = 1'b0;
          end else begin
            capture = 1'b1;
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
            busy_d  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          done    = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register for the FSM, the counter and the registered handshake
  // outputs. Reset clears all of them, which abandons any in-flight
  // transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      ready   <= ready_d;
    end
  end

  // Request fields are captured at acceptance.
  // Inputs that change while the transaction waits therefore have no effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      we_q    <= we;
      base_q  <= req_base;
      wdata_q <= wdata;
    end
  end

endmodule

// Top level: two port controllers sharing one word-organised storage array.
module mem_lat_line #(
  parameter int    WORD_WIDTH = 16,
  parameter int    ADDR_WIDTH = 16,
  parameter int    DEPTH      = 256,
  parameter int    LINE_WORDS = 4,
  parameter int    I_LATENCY  = 2,
  parameter int    D_LATENCY  = 3,
  parameter string INIT_FILE  = ""
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_req,
  input  logic                             i_we,
  input  logic [ADDR_WIDTH-1:0]            i_addr,
  input  logic [WORD_WIDTH*LINE_WORDS-1:0] i_wdata,
  output logic [WORD_WIDTH*LINE_WORDS-1:0] i_rdata,
  output logic                             i_ready,
  output logic                             i_busy,
  input  logic                             d_req,
  input  logic                             d_we,
  input  logic [ADDR_WIDTH-1:0]            d_addr,
  input  logic [WORD_WIDTH*LINE_WORDS-1:0] d_wdata,
  output logic [WORD_WIDTH*LINE_WORDS-1:0] d_rdata,
  output logic                             d_ready,
  output logic                             d_busy
);

  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LINE_W  = WORD_WIDTH * LINE_WORDS;
  localparam int MAX_LAT = (I_LATENCY > D_LATENCY) ? I_LATENCY : D_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic              i_done;
  logic              i_done_we;
  logic [IDX_W-1:0]  i_done_base;
  logic [LINE_W-1:0] i_done_wdata;
  logic              d_done;
  logic              d_done_we;
  logic [IDX_W-1:0]  d_done_base;
  logic [LINE_W-1:0] d_done_wdata;

  mem_lat_line_port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W),
    .LINE_W     (LINE_W),
    .LINE_WORDS (LINE_WORDS),
    .LATENCY    (I_LATENCY),
    .CNT_W      (CNT_W)
  ) u_i_port (
    .clk        (clk),
    .reset      (reset),
    .req        (i_req),
    .we         (i_we),
    .addr       (i_addr),
    .wdata      (i_wdata),
    .busy       (i_busy),
    .ready      (i_ready),
    .done       (i_done),
    .done_we    (i_done_we),
    .done_base  (i_done_base),
    .done_wdata (i_done_wdata)
  );

  mem_lat_line_port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W),
    .LINE_W     (LINE_W),
    .LINE_WORDS (LINE_WORDS),
    .LATENCY    (D_LATENCY),
    .CNT_W      (CNT_W)
  ) u_d_port (
    .clk        (clk),
    .reset      (reset),
    .req        (d_req),
    .we         (d_we),
    .addr       (d_addr),
    .wdata      (d_wdata),
    .busy       (d_busy),
    .ready      (d_ready),
    .done       (d_done),
    .done_we    (d_done_we),
    .done_base  (d_done_base),
    .done_wdata (d_done_wdata)
  );

  // Line write commit.
  // The D-port write is issued after the I-port write. When both ports write
  // the same line on the same edge, the D-port data therefore wins word by word.
  always_ff @(posedge clk) begin
    if (i_done && i_done_we) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        mem[i_done_base | IDX_W'(k)] <= i_done_wdata[k*WORD_WIDTH +: WORD_WIDTH];
      end
    end
    if (d_done && d_done_we) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        mem[d_done_base | IDX_W'(k)] <= d_done_wdata[k*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // I-port read line.
  // The line is sampled from pre-edge storage, so a write completing on the
  // same edge is not seen. The value is held until the next read completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rdata <= '0;
    end else if (i_done && !i_done_we) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        i_rdata[k*WORD_WIDTH +: WORD_WIDTH] <= mem[i_done_base | IDX_W'(k)];
      end
    end
  end

  // D-port read line, following the same rules as the I-port read line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_rdata <= '0;
    end else if (d_done && !d_done_we) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        d_rdata[k*WORD_WIDTH +: WORD_WIDTH] <= mem[d_done_base | IDX_W'(k)];
      end
    end
  end

endmodule

// File: tb/tb_mem_lat_line.sv
// Testbench for mem_lat_line.
// Drivers push transaction descriptors into per-port queues. A monitor pops a
// descriptor at the cycle its ready pulse is due. It checks the pulse against
// a word-array reference model, which applies reads before writes and lets
// the D-port write last.
module tb_mem_lat_line;

  localparam int WW     = 16;
  localparam int AW     = 16;
  localparam int DEPTH  = 256;
  localparam int LWORDS = 4;
  localparam int IL     = 2;
  localparam int DL     = 3;
  localparam int LW     = WW * LWORDS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0;
  logic          i_we = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [LW-1:0] i_wdata = '0;
  logic [LW-1:0] i_rdata;
  logic          i_ready;
  logic          i_busy;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_ready;
  logic          d_busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit prev_ir = 1'b0;
  bit prev_dr = 1'b0;

  typedef struct {
    bit            we;
    int            base;
    logic [LW-1:0] wdata;
    int            acc;
    int            due;
  } txn_t;

  txn_t q_i[$];
  txn_t q_d[$];
  logic [WW-1:0] model_mem [DEPTH];
  logic [LW-1:0] last_i = '0;
  logic [LW-1:0] last_d = '0;

  mem_lat_line #(
    .WORD_WIDTH (WW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .LINE_WORDS (LWORDS),
    .I_LATENCY  (IL),
    .D_LATENCY  (DL),
    .INIT_FILE  ("")
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_we    (i_we),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .i_rdata (i_rdata),
    .i_ready (i_ready),
    .i_busy  (i_busy),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .d_busy  (d_busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter: value N seen at a negedge means N rising edges have occurred
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [LW-1:0] model_read(input int base);
    logic [LW-1:0] r;
    r = '0;
    for (int k = 0; k < LWORDS; k++) r[k*WW +: WW] = model_mem[base + k];
    return r;
  endfunction

  task automatic model_write(input int base, input logic [LW-1:0] w);
    for (int k = 0; k < LWORDS; k++) model_mem[base + k] = w[k*WW +: WW];
  endtask

  // Issue one transaction at a negedge while the port is idle or in its ready cycle.
  // Returns at the negedge of the ready cycle (gap 0, req left for the next call),
  // or after gap further idle cycles with req dropped.
  task automatic applyStimulus(input bit on_d, input bit we, input logic [AW-1:0] addr,
                               input logic [LW-1:0] wdata, input int gap);
    txn_t t;
    t.we    = we;
    t.base  = (int'(addr) % DEPTH) & ~(LWORDS - 1);
    t.wdata = wdata;
    t.acc   = cyc + 1;
    t.due   = cyc + (on_d ? DL : IL);
    if (on_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      q_d.push_back(t);
    end else begin
      i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata;
      q_i.push_back(t);
    end
    @(posedge clk);
    @(negedge clk);
    while (cyc < t.due) begin
      if (on_d) begin
        d_we = 1'($urandom); d_addr = AW'($urandom); d_wdata = {$urandom, $urandom};
        if (gap != 0) d_req = 1'($urandom);
      end else begin
        i_we = 1'($urandom); i_addr = AW'($urandom); i_wdata = {$urandom, $urandom};
        if (gap != 0) i_req = 1'($urandom);
      end
      @(negedge clk);
    end
    if (gap > 0) begin
      if (on_d) d_req = 1'b0;
      else i_req = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  // Monitor: busy/ready timing each cycle, line data at each completion
  always @(negedge clk) begin
    txn_t ti;
    txn_t td;
    bit   fi;
    bit   fd;
    bit   bi;
    bit   bd;
    if (mon_en) begin
      bi = 1'b0;
      bd = 1'b0;
      foreach (q_i[k]) if (q_i[k].acc <= cyc && cyc < q_i[k].due) bi = 1'b1;
      foreach (q_d[k]) if (q_d[k].acc <= cyc && cyc < q_d[k].due) bd = 1'b1;
      checkOutput("i_busy", LW'(i_busy), LW'(bi));
      checkOutput("d_busy", LW'(d_busy), LW'(bd));
      fi = (q_i.size() > 0) && (q_i[0].due <= cyc);
      fd = (q_d.size() > 0) && (q_d[0].due <= cyc);
      checkOutput("i_ready", LW'(i_ready), LW'(fi));
      checkOutput("d_ready", LW'(d_ready), LW'(fd));
      if (i_ready) checkOutput("i_ready_gap", LW'(prev_ir), '0);
      if (d_ready) checkOutput("d_ready_gap", LW'(prev_dr), '0);
      if (fi) ti = q_i.pop_front();
      if (fd) td = q_d.pop_front();
      if (fi && !ti.we) last_i = model_read(ti.base);
      if (fd && !td.we) last_d = model_read(td.base);
      if (fi && ti.we) model_write(ti.base, ti.wdata);
      if (fd && td.we) model_write(td.base, td.wdata);
      if (fi) checkOutput("i_rdata", i_rdata, last_i);
      if (fd) checkOutput("d_rdata", d_rdata, last_d);
    end
    prev_ir = i_ready;
    prev_dr = d_ready;
  end

  // Watchdog
  initial begin
    #2000000;
    fails++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [LW-1:0] line24;
    logic [LW-1:0] line40;
    logic [LW-1:0] line_a;
    logic [LW-1:0] line_b;
    logic [LW-1:0] line_c;
    logic [LW-1:0] rst_line;
    line24 = {16'h6200, 16'hf41c, 16'h6100, 16'hf01c};
    line40 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    line_a = {16'haaa3, 16'haaa2, 16'haaa1, 16'haaa0};
    line_b = {16'hbbb3, 16'hbbb2, 16'hbbb1, 16'hbbb0};
    line_c = {16'hccc3, 16'hccc2, 16'hccc1, 16'hccc0};

    // Reset, then idle outputs for 10 cycles
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", LW'({i_ready, i_busy, d_ready, d_busy}), '0);
    checkOutput("reset_rdata", i_rdata | d_rdata, '0);
    reset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checkOutput("idle_ctrl", LW'({i_ready, i_busy, d_ready, d_busy}), '0);
      checkOutput("idle_rdata", i_rdata | d_rdata, '0);
    end
    mon_en = 1'b1;

    // Preload every line through the D-port, back to back
    for (int l = 0; l < DEPTH / LWORDS; l++)
      applyStimulus(1'b1, 1'b1, AW'(l * LWORDS), {$urandom, $urandom}, (l == DEPTH / LWORDS - 1) ? 1 : 0);

    // I-port read with address wrap
    applyStimulus(1'b1, 1'b1, 16'h0024, line24, 1);
    applyStimulus(1'b0, 1'b0, 16'h0025, '0, 1);
    checkOutput("iread_0025", i_rdata, line24);
    applyStimulus(1'b0, 1'b0, 16'h0125, '0, 1);
    checkOutput("iread_0125_wrap", i_rdata, line24);

    // D-port write then read of the same line
    applyStimulus(1'b1, 1'b1, 16'h0040, line40, 1);
    applyStimulus(1'b1, 1'b0, 16'h0043, '0, 1);
    checkOutput("dread_0043", d_rdata, line40);

    // Both ports write line 0x80 on the same edge
    fork
      applyStimulus(1'b1, 1'b1, 16'h0080, line_b, 1);
      begin
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 16'h0082, line_a, 1);
      end
    join
    applyStimulus(1'b0, 1'b0, 16'h0080, '0, 1);
    checkOutput("dual_write_d_wins", i_rdata, line_b);

    // I-read and D-write of line 0x80 complete on the same edge
    fork
      applyStimulus(1'b1, 1'b1, 16'h0081, line_c, 1);
      begin
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'h0083, '0, 1);
      end
    join
    checkOutput("same_edge_read_old", i_rdata, line_b);
    applyStimulus(1'b1, 1'b0, 16'h0080, '0, 1);
    checkOutput("same_edge_write_done", d_rdata, line_c);

    // I-port request held high across several reads
    for (int n = 0; n < 6; n++)
      applyStimulus(1'b0, 1'b0, AW'($urandom), '0, (n == 5) ? 1 : 0);

    // Random concurrent traffic on both ports
    fork
      for (int n = 0; n < 120; n++)
        applyStimulus(1'b0, 1'($urandom), AW'($urandom), {$urandom, $urandom},
                      (n == 119) ? 1 : int'($urandom_range(0, 2)));
      for (int n = 0; n < 120; n++)
        applyStimulus(1'b1, 1'($urandom), AW'($urandom), {$urandom, $urandom},
                      (n == 119) ? 1 : int'($urandom_range(0, 2)));
    join

    // Reset in the middle of a D-port write to line 0x90
    mon_en = 1'b0;
    rst_line = {$urandom, $urandom};
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0090; d_wdata = rst_line;
    @(posedge clk);
    @(negedge clk);
    d_req = 1'b0;
    checkOutput("rst_pre_busy", LW'(d_busy), LW'(1'b1));
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_async_ctrl", LW'({i_ready, i_busy, d_ready, d_busy}), '0);
    checkOutput("rst_async_rdata", i_rdata | d_rdata, '0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_hold_ctrl", LW'({d_ready, d_busy}), '0);
    end
    reset = 1'b0;
    last_i = '0;
    last_d = '0;
    @(negedge clk);
    checkOutput("rst_after_ctrl", LW'({d_ready, d_busy}), '0);
    mon_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h0091, '0, 1);
    applyStimulus(1'b0, 1'b0, 16'h0092, '0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
